cmp_unit_pipe: RTL and testbench

Parametrised successor to the system's compare unit. Adds configurable operand width, selectable signed/unsigned comparison, and a running MAX/MIN accumulator with a saturating sample counter and read-and-clear. Adds a fully pipelined result path with configurable latency. Sits in the ALU datapath beside the arithmetic and logic units, receives its enable from the ALU function decode, and returns a registered result plus a one-cycle valid flag.

---
 rtl/cmp_unit_pipe_if.sv | 16 +
 rtl/cmp_unit_pipe.sv | 64 ++++++
 tb/tb_cmp_unit_pipe.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cmp_unit_pipe_if.sv
// cmp_unit_pipe_if: operand/issue and result/accumulator-status bundle for cmp_unit_pipe.
interface cmp_unit_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CMP_EN;
    logic [3:0]       ALU_FUN;
    logic [WIDTH-1:0] CMP_OUT;
    logic             CMP_Flag;
    logic [CNT_W-1:0] ACC_CNT;
    logic             ACC_VLD;
    modport master (output A, B, CMP_EN, ALU_FUN, input CMP_OUT, CMP_Flag, ACC_CNT, ACC_VLD);
    modport slave (input A, B, CMP_EN, ALU_FUN, output CMP_OUT, CMP_Flag, ACC_CNT, ACC_VLD);
endinterface

// File: rtl/cmp_unit_pipe.sv
// cmp_unit_pipe: signed/unsigned compare plus MAX/MIN accumulator with a LAT-stage result pipeline.
module cmp_unit_pipe #(
    parameter int WIDTH = 16,
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input logic         clk,
    input logic         RST,
    cmp_unit_pipe_if.slave bus
);
    localparam logic [2:0] OP_EQ  = 3'd1;
    localparam logic [2:0] OP_GT  = 3'd2;
    localparam logic [2:0] OP_LT  = 3'd3;
    localparam logic [2:0] OP_MAX = 3'd4;
    localparam logic [2:0] OP_MIN = 3'd5;
    localparam logic [2:0] OP_CLR = 3'd6;
    logic [WIDTH-1:0] acc, nxt_acc, res;
    logic [CNT_W-1:0] cnt;
    logic             vld, sgn, eq, gt, lt, a_gt_acc, a_lt_acc, acc_op;
    logic [2:0]       op;
    logic [WIDTH:0]   pipe [LAT];
    always_comb begin
        op       = bus.ALU_FUN[2:0];
        sgn      = bus.ALU_FUN[3];
        eq       = bus.A == bus.B;
        gt       = sgn ? $signed(bus.A) > $signed(bus.B) : bus.A > bus.B;
        lt       = sgn ? $signed(bus.A) < $signed(bus.B) : bus.A < bus.B;
        a_gt_acc = sgn ? $signed(bus.A) > $signed(acc) : bus.A > acc;
        a_lt_acc = sgn ? $signed(bus.A) < $signed(acc) : bus.A < acc;
        acc_op   = op == OP_MAX || op == OP_MIN;
        // An empty accumulator always takes the sample, whatever the compare says
        nxt_acc  = !vld ? bus.A
                 : (op == OP_MAX ? a_gt_acc : a_lt_acc) ? bus.A : acc;
        res      = op == OP_EQ  ? {{(WIDTH-1){1'b0}}, eq}
                 : op == OP_GT  ? {{(WIDTH-1){1'b0}}, gt}
                 : op == OP_LT  ? {{(WIDTH-1){1'b0}}, lt}
                 : acc_op       ? nxt_acc
                 : op == OP_CLR ? acc : '0;
    end
    always_ff @(posedge clk) begin
        if (!RST) begin
            acc <= '0;
            cnt <= '0;
            vld <= 1'b0;
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            if (bus.CMP_EN && acc_op) begin
                acc <= nxt_acc;
                cnt <= &cnt ? cnt : cnt + 1'b1;
                vld <= 1'b1;
            end else if (bus.CMP_EN && op == OP_CLR) begin
                acc <= '0;
                cnt <= '0;
                vld <= 1'b0;
            end
            pipe[0] <= bus.CMP_EN ? {1'b1, res} : '0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign bus.CMP_OUT  = pipe[LAT-1][WIDTH-1:0];
    assign bus.CMP_Flag = pipe[LAT-1][WIDTH];
    assign bus.ACC_CNT  = cnt;
    assign bus.ACC_VLD  = vld;
endmodule

// File: tb/tb_cmp_unit_pipe.sv
// tb_cmp_unit_pipe: three parameterisations driven in lockstep and checked against an issue-history model.
module tb_cmp_unit_pipe;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    cmp_unit_pipe_if #(.WIDTH(16), .CNT_W(8)) b1 ();
    cmp_unit_pipe_if #(.WIDTH(16), .CNT_W(2)) b3 ();
    cmp_unit_pipe_if #(.WIDTH(16), .CNT_W(3)) b4 ();
    cmp_unit_pipe #(.WIDTH(16), .LAT(1), .CNT_W(8)) d1 (.clk(clk), .RST(rst), .bus(b1.slave));
    cmp_unit_pipe #(.WIDTH(16), .LAT(3), .CNT_W(2)) d3 (.clk(clk), .RST(rst), .bus(b3.slave));
    cmp_unit_pipe #(.WIDTH(16), .LAT(4), .CNT_W(3)) d4 (.clk(clk), .RST(rst), .bus(b4.slave));
    always #5 clk = ~clk;
    // Model: per-edge record of {flag,result}; an output shows the record from LAT-1 edges back
    logic [16:0] hist [1024];
    int          t = -1;
    int          last_rst = -1;
    logic [15:0] acc;
    int          cnt;
    bit          vld;
    function automatic longint val(logic [15:0] x, bit s);
        return s ? longint'($signed(x)) : longint'({48'b0, x});
    endfunction
    function automatic logic [16:0] exp_at(int lat);
        int idx = t - lat + 1;
        return (idx >= 0 && idx > last_rst) ? hist[idx] : 17'b0;
    endfunction
    function automatic int exp_cnt(int w);
        int m = (1 << w) - 1;
        return cnt > m ? m : cnt;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d obs=%0h exp=%0h", tag, t, obs, exp);
        end
    endtask
    task automatic model(input bit en, input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b, input bit r);
        logic [15:0] res;
        bit s = fun[3];
        t++;
        res = '0;
        if (!r) begin
            last_rst = t;
            hist[t] = '0;
            acc = '0; cnt = 0; vld = 0;
            return;
        end
        if (!en) begin
            hist[t] = '0;
            return;
        end
        case (fun[2:0])
            3'd1: res = 16'(a == b);
            3'd2: res = 16'(val(a, s) > val(b, s));
            3'd3: res = 16'(val(a, s) < val(b, s));
            3'd4, 3'd5: begin
                if (!vld || (fun[2:0] == 3'd4 ? val(a, s) > val(acc, s) : val(a, s) < val(acc, s))) acc = a;
                vld = 1; cnt++; res = acc;
            end
            3'd6: begin
                res = acc; acc = '0; cnt = 0; vld = 0;
            end
            default: res = '0;
        endcase
        hist[t] = {1'b1, res};
    endtask
    task automatic step(input bit en, input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b, input bit r = 1);
        logic [16:0] e;
        rst = r;
        b1.CMP_EN = en; b1.ALU_FUN = fun; b1.A = a; b1.B = b;
        b3.CMP_EN = en; b3.ALU_FUN = fun; b3.A = a; b3.B = b;
        b4.CMP_EN = en; b4.ALU_FUN = fun; b4.A = a; b4.B = b;
        @(posedge clk);
        model(en, fun, a, b, r);
        #1;
        e = exp_at(1);
        chk("l1_out", 64'(b1.CMP_OUT), 64'(e[15:0]));
        chk("l1_flag", 64'(b1.CMP_Flag), 64'(e[16]));
        chk("l1_cnt", 64'(b1.ACC_CNT), 64'(exp_cnt(8)));
        chk("l1_vld", 64'(b1.ACC_VLD), 64'(vld));
        e = exp_at(3);
        chk("l3_out", 64'(b3.CMP_OUT), 64'(e[15:0]));
        chk("l3_flag", 64'(b3.CMP_Flag), 64'(e[16]));
        chk("l3_cnt", 64'(b3.ACC_CNT), 64'(exp_cnt(2)));
        chk("l3_vld", 64'(b3.ACC_VLD), 64'(vld));
        e = exp_at(4);
        chk("l4_out", 64'(b4.CMP_OUT), 64'(e[15:0]));
        chk("l4_flag", 64'(b4.CMP_Flag), 64'(e[16]));
        chk("l4_cnt", 64'(b4.ACC_CNT), 64'(exp_cnt(3)));
        chk("l4_vld", 64'(b4.ACC_VLD), 64'(vld));
    endtask
    initial begin
        acc = '0; cnt = 0; vld = 0;
        step(1, 4'b0100, 16'h0055, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 4'b0010, 16'h8000, 16'h0001);
        step(1, 4'b1010, 16'h8000, 16'h0001);
        step(1, 4'b1011, 16'h8000, 16'h0001);
        step(1, 4'b0001, 16'h1234, 16'h1234);
        step(1, 4'b0001, 16'h0005, 16'h0005);
        step(0, 4'b0010, 16'h0007, 16'h0002);
        step(1, 4'b0010, 16'h0007, 16'h0002);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(1, 4'b0110, 0, 0);
        step(1, 4'b0100, 16'd3, 0);
        step(1, 4'b0100, 16'd9, 0);
        step(1, 4'b0100, 16'd4, 0);
        step(1, 4'b0110, 0, 0);
        step(1, 4'b1101, 16'h0002, 0);
        step(1, 4'b1101, 16'hFFFE, 0);
        step(1, 4'b0100, 16'h0003, 0);
        step(1, 4'b0110, 0, 0);
        step(1, 4'b0110, 0, 0);
        step(1, 4'b0100, 16'h0011, 0);
        step(1, 4'b0110, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 4'b0100, 16'(10 + 7 * i - 3 * (i % 2) * 5), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 4'b0001, 16'd1, 16'd1);
        step(1, 4'b0100, 16'd8, 0);
        step(1, 4'b0010, 16'd9, 16'd2);
        step(1, 4'b0100, 16'd7, 0, 0);
        step(0, 0, 0, 0);
        step(1, 4'b0100, 16'd42, 0);
        for (int i = 0; i < 10; i++) step(0, 4'($urandom), 16'($urandom), 16'($urandom));
        step(1, 4'b0111, 16'h1111, 16'h2222);
        step(1, 4'b1111, 16'h3333, 16'h3333);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic [15:0] a = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            logic [15:0] b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            step($urandom_range(0, 4) != 0, 4'($urandom), a, b, $urandom_range(0, 59) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
